// File: rtl/usr_multi_shift.sv
// Universal shift register with free-running and counted multi-step operations.
// A counted operation repeats a single step amt times, then pulses done for one cycle.
module usr_multi_shift #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_left,
  input  logic             ser_right,
  output logic [WIDTH-1:0] out,
  output logic             so_msb,
  output logic             so_lsb,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | free-run on mode each edge, or accept a start request
  // BUSY  | counted operation running on the latched mode, one step per edge
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROTL = 3'b100;
  localparam logic [2:0] M_ROTR = 3'b101;
  localparam logic [2:0] M_ASHR = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  localparam logic [AMT_W-1:0] ONE = AMT_W'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic [AMT_W-1:0] count, count_nxt;
  logic [2:0]       mode_q, mode_nxt;
  logic             done_nxt;

  function automatic logic [WIDTH-1:0] step_val(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] pin,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    r = v;
    case (m)
      M_HOLD: r = v;
      M_SHL:  r = {v[WIDTH-2:0], sr};
      M_SHR:  r = {sl, v[WIDTH-1:1]};
      M_LOAD: r = pin;
      M_ROTL: r = {v[WIDTH-2:0], v[WIDTH-1]};
      M_ROTR: r = {v[0], v[WIDTH-1:1]};
      M_ASHR: r = {v[WIDTH-1], v[WIDTH-1:1]};
      M_CLR:  r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic is_counted(input logic [2:0] m);
    return (m == M_SHL) || (m == M_SHR) || (m == M_ROTL) ||
           (m == M_ROTR) || (m == M_ASHR);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      out    <= '0;
      count  <= '0;
      mode_q <= M_HOLD;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      out    <= out_nxt;
      count  <= count_nxt;
      mode_q <= mode_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    out_nxt   = out;
    count_nxt = count;
    mode_nxt  = mode_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (!start) begin
          out_nxt = step_val(mode, out, par_in, ser_left, ser_right);
        end else if (!is_counted(mode)) begin
          out_nxt  = step_val(mode, out, par_in, ser_left, ser_right);
          done_nxt = 1'b1;
        end else if (amt == '0) begin
          done_nxt = 1'b1;
        end else begin
          out_nxt   = step_val(mode, out, par_in, ser_left, ser_right);
          mode_nxt  = mode;
          count_nxt = amt - ONE;
          if (amt == ONE) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        // par_in is irrelevant here: only shift/rotate modes are ever latched
        out_nxt   = step_val(mode_q, out, par_in, ser_left, ser_right);
        count_nxt = count - ONE;
        if (count == ONE) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy   = (state == BUSY);
  assign so_msb = out[WIDTH-1];
  assign so_lsb = out[0];

endmodule

// File: tb/tb_usr_multi_shift.sv
// Bench for usr_multi_shift: directed vectors, a per-cycle reference model,
// and literal expectations at the notable points of each scenario.
module tb_usr_multi_shift;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    mode = 3'b000;
  logic          start = 1'b0;
  logic [AW-1:0] amt = '0;
  logic [W-1:0]  par_in = '0;
  logic          ser_left = 1'b0;
  logic          ser_right = 1'b0;
  logic [W-1:0]  out;
  logic          so_msb, so_lsb, busy, done;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  usr_multi_shift #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .start(start), .amt(amt),
    .par_in(par_in), .ser_left(ser_left), .ser_right(ser_right),
    .out(out), .so_msb(so_msb), .so_lsb(so_lsb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: remaining-step counter plus a pure arithmetic step rule.
  logic [W-1:0] m_out = '0;
  int           m_rem = 0;
  logic [2:0]   m_mode = 3'b000;
  logic         m_done = 1'b0;

  function automatic logic [W-1:0] apply(input logic [2:0] m, input logic [W-1:0] v);
    logic signed [W-1:0] s;
    s = v;
    case (m)
      3'd1: return (v << 1) | W'(ser_right);
      3'd2: return (v >> 1) | (W'(ser_left) << (W-1));
      3'd3: return par_in;
      3'd4: return (v << 1) | (v >> (W-1));
      3'd5: return (v >> 1) | (v << (W-1));
      3'd6: return W'(s >>> 1);
      3'd7: return '0;
      default: return v;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = '0; m_rem = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_out = apply(m_mode, m_out);
        m_rem = m_rem - 1;
        m_done = (m_rem == 0);
      end else if (!start) begin
        m_out = apply(mode, m_out);
      end else if (mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) begin
        if (amt == 0) m_done = 1'b1;
        else begin
          m_out  = apply(mode, m_out);
          m_mode = mode;
          m_rem  = int'(amt) - 1;
          m_done = (m_rem == 0);
        end
      end else begin
        m_out = apply(mode, m_out);
        m_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("model_out", 64'(out), 64'(m_out));
      chk("model_busy", 64'(busy), 64'(m_rem > 0));
      chk("model_done", 64'(done), 64'(m_done));
      chk("so_msb", 64'(so_msb), 64'(m_out[W-1]));
      chk("so_lsb", 64'(so_lsb), 64'(m_out[0]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    start = 1'b0; mode = 3'b000;
  endtask

  initial begin
    #3;
    chk("rst_out", 64'(out), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    @(posedge clk); #2;
    rst_n = 1'b1; chk_en = 1'b1;

    // rotl 0xA5 by 3
    mode = 3'b011; par_in = 8'hA5; cyc();
    chk("load_a5", 64'(out), 64'hA5);
    mode = 3'b100; start = 1'b1; amt = 4'd3; cyc(); idle_in();
    chk("rotl_s1", 64'(out), 64'h4B);
    chk("rotl_busy1", 64'(busy), 64'h1);
    cyc();
    chk("rotl_busy2", 64'(busy), 64'h1);
    cyc();
    chk("rotl_out", 64'(out), 64'h2D);
    chk("rotl_done", 64'(done), 64'h1);
    chk("rotl_idle", 64'(busy), 64'h0);
    cyc();
    chk("rotl_done_off", 64'(done), 64'h0);

    // ashr 0x90 by 2
    mode = 3'b011; par_in = 8'h90; cyc();
    mode = 3'b110; start = 1'b1; amt = 4'd2; cyc(); idle_in();
    chk("ashr_s1", 64'(out), 64'hC8);
    chk("ashr_busy", 64'(busy), 64'h1);
    cyc();
    chk("ashr_out", 64'(out), 64'hE4);
    chk("ashr_done", 64'(done), 64'h1);
    cyc();

    // shl with amt=0
    mode = 3'b011; par_in = 8'h3C; cyc();
    mode = 3'b001; start = 1'b1; amt = 4'd0; cyc(); idle_in();
    chk("amt0_out", 64'(out), 64'h3C);
    chk("amt0_busy", 64'(busy), 64'h0);
    chk("amt0_done", 64'(done), 64'h1);
    cyc();
    chk("amt0_done_off", 64'(done), 64'h0);

    // shr by 5 with ser_left=1; inputs churned while busy
    ser_left = 1'b1;
    mode = 3'b010; start = 1'b1; amt = 4'd5; cyc();
    chk("shr_s1", 64'(out), 64'h9E);
    mode = 3'b011; par_in = 8'h00; start = 1'b1; amt = 4'd7; cyc();
    mode = 3'b111; cyc();
    idle_in(); cyc();
    chk("shr_busy_late", 64'(busy), 64'h1);
    cyc();
    chk("shr_out", 64'(out), 64'hF9);
    chk("shr_done", 64'(done), 64'h1);
    mode = 3'b101; start = 1'b1; amt = 4'd1; cyc(); idle_in();
    chk("b2b_rotr", 64'(out), 64'hFC);
    chk("b2b_done", 64'(done), 64'h1);
    chk("b2b_busy", 64'(busy), 64'h0);
    cyc();
    ser_left = 1'b0;

    // started load ignores amt
    mode = 3'b011; par_in = 8'h5A; start = 1'b1; amt = 4'd9; cyc(); idle_in();
    chk("sload_out", 64'(out), 64'h5A);
    chk("sload_done", 64'(done), 64'h1);
    chk("sload_busy", 64'(busy), 64'h0);
    cyc();

    // rotl by 10 > WIDTH wraps
    mode = 3'b011; par_in = 8'h01; cyc();
    mode = 3'b100; start = 1'b1; amt = 4'd10; cyc(); idle_in();
    repeat (9) cyc();
    chk("rotl10_out", 64'(out), 64'h04);
    chk("rotl10_done", 64'(done), 64'h1);
    cyc();

    // shl by 12 flushes
    mode = 3'b011; par_in = 8'hA5; cyc();
    mode = 3'b001; start = 1'b1; amt = 4'd12; cyc(); idle_in();
    repeat (11) cyc();
    chk("flush_out", 64'(out), 64'h00);
    chk("flush_done", 64'(done), 64'h1);
    cyc();

    // free-run shl filling ones
    mode = 3'b111; cyc();
    mode = 3'b001; ser_right = 1'b1;
    repeat (8) cyc();
    chk("fill_ff", 64'(out), 64'hFF);
    idle_in(); cyc();

    // asynchronous reset in the middle of a counted op
    mode = 3'b010; start = 1'b1; amt = 4'd6; cyc(); idle_in();
    cyc();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out", 64'(out), 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_done", 64'(done), 64'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_done", 64'(done), 64'h0);
    chk("post_rst_busy", 64'(busy), 64'h0);
    chk("post_rst_out", 64'(out), 64'h0);
    cyc();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
